// File: rtl/pll_rst_seq.sv
// Lock-qualified reset sequencer: synchronises the PLL lock, releases PHY then link
// resets once lock is stable, and pulses the PLL reset when lock never arrives.
module pll_rst_seq #(
    parameter int STABLE_CYCLES  = 1200,
    parameter int LINK_DLY       = 120,
    parameter int LOCK_TIMEOUT   = 120000,
    parameter int PLL_RST_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock,
    output logic       pll_rst,
    output logic       phy_rst_n,
    output logic       link_rst_n,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    localparam int MAX_AB = (STABLE_CYCLES > LINK_DLY) ? STABLE_CYCLES : LINK_DLY;
    localparam int MAX_CD = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] STABLE_TERM  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LINK_TERM    = CNT_W'(LINK_DLY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PLLRST_TERM  = CNT_W'(PLL_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_PHY_UP    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4,
        ST_PLL_RST   = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             cnt_run_s;
    logic             lock_meta_r;
    logic             lock_sync_r;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state decode; a lock drop always beats a coinciding terminal count.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (lock_sync_r)                  state_nxt_s = ST_STABLE;
                else if (cnt_r == TIMEOUT_TERM)   state_nxt_s = ST_PLL_RST;
                else                              state_nxt_s = ST_WAIT_LOCK;
            end
            ST_STABLE: begin
                if (!lock_sync_r)                 state_nxt_s = ST_WAIT_LOCK;
                else if (cnt_r == STABLE_TERM)    state_nxt_s = ST_PHY_UP;
                else                              state_nxt_s = ST_STABLE;
            end
            ST_PHY_UP: begin
                if (!lock_sync_r)                 state_nxt_s = ST_LOST;
                else if (cnt_r == LINK_TERM)      state_nxt_s = ST_RUN;
                else                              state_nxt_s = ST_PHY_UP;
            end
            ST_RUN: begin
                if (!lock_sync_r)                 state_nxt_s = ST_LOST;
                else                              state_nxt_s = ST_RUN;
            end
            ST_LOST:                              state_nxt_s = ST_WAIT_LOCK;
            ST_PLL_RST: begin
                if (cnt_r == PLLRST_TERM)         state_nxt_s = ST_WAIT_LOCK;
                else                              state_nxt_s = ST_PLL_RST;
            end
            default:                              state_nxt_s = ST_WAIT_LOCK;
        endcase
    end

    // Shared counter: cleared on any state change, advances only in timed states.
    always_comb begin
        cnt_run_s = 1'b0;
        case (state_r)
            ST_WAIT_LOCK, ST_STABLE, ST_PHY_UP, ST_PLL_RST: cnt_run_s = 1'b1;
            default:                                        cnt_run_s = 1'b0;
        endcase
        if (state_nxt_s != state_r) cnt_nxt_s = '0;
        else if (cnt_run_s)         cnt_nxt_s = cnt_r + CNT_W'(1);
        else                        cnt_nxt_s = cnt_r;
    end

    // State, counter and outputs decoded from the next state so all move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_LOCK;
            cnt_r      <= '0;
            pll_rst    <= 1'b0;
            phy_rst_n  <= 1'b0;
            link_rst_n <= 1'b0;
            ready      <= 1'b0;
            loss_cnt   <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            pll_rst    <= (state_nxt_s == ST_PLL_RST);
            phy_rst_n  <= (state_nxt_s == ST_PHY_UP) || (state_nxt_s == ST_RUN);
            link_rst_n <= (state_nxt_s == ST_RUN);
            ready      <= (state_nxt_s == ST_RUN);
            if ((state_nxt_s == ST_LOST) && (state_r != ST_LOST) && (loss_cnt != 8'hFF)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end else begin
                loss_cnt <= loss_cnt;
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: stimulus queues expected output changes with
// their cycle stamps; a negedge monitor pops and compares each observed change.
module tb_pll_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       pll_rst;
    logic       phy_rst_n;
    logic       link_rst_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    pll_rst_seq #(
        .STABLE_CYCLES (8),
        .LINK_DLY      (4),
        .LOCK_TIMEOUT  (20),
        .PLL_RST_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lock      (lock),
        .pll_rst   (pll_rst),
        .phy_rst_n (phy_rst_n),
        .link_rst_n(link_rst_n),
        .ready     (ready),
        .state     (state),
        .loss_cnt  (loss_cnt)
    );

    typedef struct {
        int          cyc;
        logic [14:0] val;
    } ev_t;

    ev_t         sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  lc       = 8'd0;
    logic [14:0] exp_cur;
    logic [14:0] prev_t;
    bit          mon_en   = 1'b0;

    wire [14:0] dut_t = {state, pll_rst, phy_rst_n, link_rst_n, ready, loss_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] tup(input logic [2:0] st, input logic [7:0] l);
        tup = {st, (st == 3'd5), (st == 3'd2) || (st == 3'd3), (st == 3'd3), (st == 3'd3), l};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] st);
        ev_t e;
        e.cyc = c;
        e.val = tup(st, lc);
        sb_q.push_back(e);
        exp_cur = e.val;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // All tasks below start and end at a negedge.
    task automatic do_reset();
        int x;
        x = cyc;
        lc = 8'd0;
        if (exp_cur !== tup(3'd0, 8'd0)) push(x + 1, 3'd0);
        #2 rst_n = 1'b0;
        lock = 1'b0;
        #1 chk("async_reset", 32'(dut_t), 32'(tup(3'd0, 8'd0)));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_up();
        int d;
        d = cyc;
        lock = 1'b1;
        push(d + 3, 3'd1);
        push(d + 11, 3'd2);
        push(d + 15, 3'd3);
        wait_cyc(d + 16);
    endtask

    task automatic lock_down();
        int d;
        d = cyc;
        lock = 1'b0;
        lc = (lc == 8'hFF) ? 8'hFF : lc + 8'd1;
        push(d + 3, 3'd4);
        push(d + 4, 3'd0);
        wait_cyc(d + 5);
    endtask

    // Monitor: every change of the output tuple is one DUT "response".
    always @(negedge clk) begin
        if (mon_en && (dut_t !== prev_t)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event cycle=%0d actual=%0h expected=none", cyc, dut_t);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                chk("ev_value", 32'(dut_t), 32'(e.val));
            end
            prev_t = dut_t;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst_n = 1'b1;
        lock  = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset_state", 32'(dut_t), 32'(tup(3'd0, 8'd0)));
        exp_cur = tup(3'd0, 8'd0);
        prev_t  = dut_t;
        mon_en  = 1'b1;

        // Lock never arrives: PLL reset pulses of 3 cycles every 23 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push(r + 20, 3'd5);
        push(r + 23, 3'd0);
        push(r + 43, 3'd5);
        push(r + 46, 3'd0);
        wait_cyc(r + 50);

        // Plain release sequence.
        do_reset();
        lock_up();
        chk("run_loss_cnt", 32'(loss_cnt), 32'd0);

        // lock_s rises on the timeout-terminal cycle: lock wins, no pll_rst.
        do_reset();
        r = cyc;
        wait_cyc(r + 17);
        lock_up();

        // Loss from RUN then relock.
        lock_down();
        chk("loss_one", 32'(loss_cnt), 32'd1);
        lock_up();

        // Saturation of the loss counter.
        for (int i = 0; i < 260; i++) begin
            lock_down();
            lock_up();
        end
        chk("loss_sat", 32'(loss_cnt), 32'd255);

        // Short lock pulses never release the PHY.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            int d;
            d = cyc;
            lock = 1'b1;
            push(d + 3, 3'd1);
            wait_cyc(d + 5);
            lock = 1'b0;
            push(d + 8, 3'd0);
            wait_cyc(d + 10);
        end

        // lock_s falls on the STABLE terminal cycle: drop wins.
        begin
            int d;
            d = cyc;
            lock = 1'b1;
            push(d + 3, 3'd1);
            wait_cyc(d + 8);
            lock = 1'b0;
            push(d + 11, 3'd0);
            wait_cyc(d + 14);
        end

        // rst_n pulsed while in PHY_UP.
        begin
            int d;
            d = cyc;
            lock = 1'b1;
            push(d + 3, 3'd1);
            push(d + 11, 3'd2);
            wait_cyc(d + 13);
            do_reset();
        end

        wait_cyc(cyc + 4);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
